// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issuer.
//   - ALU function-select codes (driven on alu_ctrl)
//   - request opcodes that never reach the ALU (LDI, NOP)
//   - FSM state encoding
//   - default data width / register-file depth
package alu_pkg;

    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int AW   = 3;

    localparam logic [2:0] ALU_HOLD  = 3'b000;
    localparam logic [2:0] ALU_PASSA = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_MUL   = 3'b110;
    localparam logic [2:0] ALU_DIV   = 3'b111;
    localparam logic [2:0] OP_LDI    = 3'b000;
    localparam logic [2:0] OP_NOP    = 3'b011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/regfile8x8.sv
// regfile8x8: NREG x DW register file.
//   clk, rst          : clock, synchronous active-high clear of every entry
//   we, waddr, wdata  : single synchronous write port
//   ra/rb/rc_addr     : three asynchronous read ports (ra/rb = operands,
//   ra/rb/rc_data       rc = external readback)
module regfile8x8 #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] rc_addr,
    output logic [DW-1:0] rc_data
);

    logic [DW-1:0] mem_q [NREG];

    // Clear wins over write, so a reset on the writeback edge drops the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];
    assign rc_data = mem_q[rc_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: one-at-a-time operation issuer / register-file front end for
// the 8-bit ALU.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_op/dst/srca/srcb/imm      : request fields
//   bus2, bus3, alu_ctrl          : registered ALU operands / function select
//   alu_result, alu_z             : ALU outputs, stable at the writeback edge
//   done, done_z, div_err         : completion pulse, its zero flag, div-by-0
//   rd_addr, rd_data              : asynchronous register readback
module alu_issue
    import alu_pkg::*;
#(
    parameter int DW   = alu_pkg::DW,
    parameter int NREG = alu_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [2:0]    req_dst,
    input  logic [2:0]    req_srca,
    input  logic [2:0]    req_srcb,
    input  logic [DW-1:0] req_imm,
    output logic [DW-1:0] bus2,
    output logic [DW-1:0] bus3,
    output logic [2:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_z,
    output logic          done,
    output logic          done_z,
    output logic          div_err,
    input  logic [2:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    state_e        state_q;
    logic [DW-1:0] bus2_q, bus3_q, imm_q;
    logic [2:0]    ctrl_q, op_q, dst_q;
    logic          dz_q, done_q, done_z_q, div_err_q;

    logic [DW-1:0] opa, opb, wdata;
    logic          we, div_zero_d, done_z_d;
    logic [2:0]    ctrl_d;

    regfile8x8 #(.DW(DW), .NREG(NREG), .AW(3)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (dst_q),
        .wdata   (wdata),
        .ra_addr (req_srca),
        .ra_data (opa),
        .rb_addr (req_srcb),
        .rb_data (opb),
        .rc_addr (rd_addr),
        .rc_data (rd_data)
    );

    // Divide by zero is caught here, so the ALU never sees it.
    assign div_zero_d = (req_op == ALU_DIV) && (opb == '0);
    assign ctrl_d     = (req_op == OP_LDI || req_op == OP_NOP || div_zero_d) ? ALU_HOLD : req_op;

    // Writeback happens on the EXEC->IDLE edge; NOP and blocked divides skip it.
    assign we    = (state_q == ST_EXEC) && !dz_q && (op_q != OP_NOP);
    assign wdata = (op_q == OP_LDI) ? imm_q : alu_result;

    always_comb begin
        done_z_d = alu_z;
        if (dz_q || op_q == OP_NOP) done_z_d = 1'b0;
        else if (op_q == OP_LDI)    done_z_d = (imm_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bus2_q    <= '0;
            bus3_q    <= '0;
            ctrl_q    <= ALU_HOLD;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            imm_q     <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            done_z_q  <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q    <= 1'b0;
                    done_z_q  <= 1'b0;
                    div_err_q <= 1'b0;
                    if (req_valid) begin
                        state_q <= ST_EXEC;
                        bus2_q  <= opa;
                        bus3_q  <= opb;
                        ctrl_q  <= ctrl_d;
                        op_q    <= req_op;
                        dst_q   <= req_dst;
                        imm_q   <= req_imm;
                        dz_q    <= div_zero_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ctrl_q    <= ALU_HOLD;
                    done_q    <= 1'b1;
                    done_z_q  <= done_z_d;
                    div_err_q <= dz_q;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign bus2      = bus2_q;
    assign bus3      = bus3_q;
    assign alu_ctrl  = ctrl_q;
    assign done      = done_q;
    assign done_z    = done_z_q;
    assign div_err   = div_err_q;

endmodule
